// File: rtl/inport_feeder.sv
// Input-port feeder: FIFO between an external producer and the CPU "in" port.
// Show-ahead head word, one pop per rd_strobe assertion, sticky under/overflow flags.
module inport_feeder #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] EMPTY_WORD = {WIDTH{1'b0}}
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     rd_strobe,
  output logic [WIDTH-1:0]         in_port_data,
  output logic                     data_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow,
  output logic                     overflow,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             strobe_q;
  logic             underflow_q, underflow_d;
  logic             overflow_q, overflow_d;

  logic             full_s, empty_s, pop_req_s, wr_en_s, pop_en_s;

  // Write and pop qualification; full blocks writes even when a pop lands in the same cycle
  always_comb begin
    full_s    = (count_q == FULL_CNT);
    empty_s   = (count_q == {CW{1'b0}});
    pop_req_s = rd_strobe & ~strobe_q;
    wr_en_s   = wr_valid & ~full_s;
    pop_en_s  = pop_req_s & ~empty_s;
  end

  // Next-state for pointers, occupancy and sticky flags
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_en_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // A fresh event outranks clear_flags in the same cycle
    underflow_d = (pop_req_s & empty_s) | (underflow_q & ~clear_flags);
    overflow_d  = (wr_valid & full_s) | (overflow_q & ~clear_flags);
  end

  // State registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr_q    <= {AW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      strobe_q    <= rd_strobe;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is never cleared; pointers alone define its contents
  always_ff @(posedge Clock) begin
    if (!Reset && wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Output drive
  always_comb begin
    wr_ready     = ~full_s;
    data_valid   = ~empty_s;
    count        = count_q;
    underflow    = underflow_q;
    overflow     = overflow_q;
    in_port_data = empty_s ? EMPTY_WORD : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_inport_feeder.sv
// Bench for inport_feeder: hand-computed vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_inport_feeder;

  logic        Clock = 1'b0;
  logic        Reset, wr_valid, rd_strobe, clear_flags;
  logic [31:0] wr_data;
  logic        wr_ready, data_valid, underflow, overflow;
  logic [31:0] in_port_data;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  inport_feeder #(.WIDTH(32), .DEPTH(8), .EMPTY_WORD(32'h0000_0000)) dut (
    .Clock(Clock), .Reset(Reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_strobe(rd_strobe), .in_port_data(in_port_data),
    .data_valid(data_valid), .count(count), .underflow(underflow),
    .overflow(overflow), .clear_flags(clear_flags)
  );

  always #5 Clock = ~Clock;

  // Reference model: a queue of words plus the previous strobe level
  logic [31:0] mq[$];
  logic        m_prev = 1'b0, m_uf = 1'b0, m_of = 1'b0;

  task automatic model_update(input logic rst, wv, input logic [31:0] wd, input logic rs, cf);
    logic pop_req, was_empty, was_full, uf_set, of_set;
    if (rst) begin
      mq.delete();
      m_prev = 1'b0; m_uf = 1'b0; m_of = 1'b0;
    end else begin
      pop_req   = rs && !m_prev;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == 8);
      uf_set    = pop_req && was_empty;
      of_set    = wv && was_full;
      if (pop_req && !was_empty) void'(mq.pop_front());
      if (wv && !was_full) mq.push_back(wd);
      m_uf   = uf_set | (m_uf & !cf);
      m_of   = of_set | (m_of & !cf);
      m_prev = rs;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, wv, input logic [31:0] wd, input logic rs, cf);
    Reset = rst; wr_valid = wv; wr_data = wd; rd_strobe = rs; clear_flags = cf;
    @(posedge Clock);
    model_update(rst, wv, wd, rs, cf);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string nm);
    logic [31:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
    chk({nm, ".count"}, {28'h0, count}, 32'(mq.size()));
    chk({nm, ".data"}, in_port_data, exp_data);
    chk({nm, ".ready"}, {31'h0, wr_ready}, {31'h0, mq.size() != 8});
    chk({nm, ".valid"}, {31'h0, data_valid}, {31'h0, mq.size() != 0});
    chk({nm, ".uf"}, {31'h0, underflow}, {31'h0, m_uf});
    chk({nm, ".of"}, {31'h0, overflow}, {31'h0, m_of});
  endtask

  typedef struct {
    logic rst, wv; logic [31:0] wd; logic rs, cf;
    logic [3:0] cnt; logic [31:0] dat; logic rdy, dv, uf, of;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic rst, wv, logic [31:0] wd, logic rs, cf,
                              logic [3:0] cnt, logic [31:0] dat, logic uf);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wd = wd; v.rs = rs; v.cf = cf;
    v.cnt = cnt; v.dat = dat; v.rdy = (cnt != 4'd8); v.dv = (cnt != 4'd0);
    v.uf = uf; v.of = 1'b0;
    return v;
  endfunction

  initial begin
    Reset = 1'b1; wr_valid = 1'b0; wr_data = 32'h0; rd_strobe = 1'b0; clear_flags = 1'b0;

    //              rst   wv    wd        rs    cf    cnt   data      uf
    tbl[0]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'hA, 1'b0, 1'b0, 4'd1, 32'hA, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 4'd2, 32'hA, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 4'd3, 32'hA, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd2, 32'hB, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd2, 32'hB, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd2, 32'hB, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd2, 32'hB, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd1, 32'hC, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 32'hC, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 32'hD, 1'b1, 1'b0, 4'd1, 32'hD, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd1, 32'hD, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 32'hD, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'h0, 1'b1);
    tbl[20] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].rs, tbl[i].cf);
      chk($sformatf("tbl%0d.count", i), {28'h0, count}, {28'h0, tbl[i].cnt});
      chk($sformatf("tbl%0d.data", i), in_port_data, tbl[i].dat);
      chk($sformatf("tbl%0d.ready", i), {31'h0, wr_ready}, {31'h0, tbl[i].rdy});
      chk($sformatf("tbl%0d.valid", i), {31'h0, data_valid}, {31'h0, tbl[i].dv});
      chk($sformatf("tbl%0d.uf", i), {31'h0, underflow}, {31'h0, tbl[i].uf});
      chk($sformatf("tbl%0d.of", i), {31'h0, overflow}, {31'h0, tbl[i].of});
    end

    // Fill, overflow, full-with-pop (no write-through), then drain in order
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    chk("full.ready", {31'h0, wr_ready}, 32'h0);
    chk("full.count", {28'h0, count}, 32'd8);
    chk("full.head", in_port_data, 32'd1);
    step(1'b0, 1'b1, 32'h99, 1'b0, 1'b0);
    chk("ovf.flag", {31'h0, overflow}, 32'h1);
    chk("ovf.count", {28'h0, count}, 32'd8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf.clear", {31'h0, overflow}, 32'h0);
    step(1'b0, 1'b1, 32'h77, 1'b1, 1'b0);
    chk("fullpop.count", {28'h0, count}, 32'd7);
    chk("fullpop.of", {31'h0, overflow}, 32'h1);
    idle();
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("drain.word%0d", k), in_port_data, 32'(k));
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      idle();
    end
    chk("drain.valid", {31'h0, data_valid}, 32'h0);
    chk("drain.empty_word", in_port_data, 32'h0);

    // Write coinciding with a strobe rising edge at count=4
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    chk("wp.count", {28'h0, count}, 32'd4);
    chk("wp.head", in_port_data, 32'd2);
    idle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wp.order%0d", k), in_port_data, (k == 3) ? 32'h55 : 32'(k + 2));
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      idle();
    end
    chk("wp.empty", {28'h0, count}, 32'd0);

    // Pointer wrap: keep six entries in flight while cycling 20 words through
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 32'(200 + i), 1'b1, 1'b0);
      idle();
      check_model($sformatf("wrap%0d", i));
    end

    // Reset with stored words and a concurrent write
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i + 7), 1'b0, 1'b0);
    chk("pre_rst.count", {28'h0, count}, 32'd5);
    chk("pre_rst.uf", {31'h0, underflow}, 32'h1);
    step(1'b1, 1'b1, 32'hEE, 1'b0, 1'b0);
    chk("rst.count", {28'h0, count}, 32'd0);
    chk("rst.valid", {31'h0, data_valid}, 32'h0);
    chk("rst.ready", {31'h0, wr_ready}, 32'h1);
    chk("rst.uf", {31'h0, underflow}, 32'h0);
    chk("rst.of", {31'h0, overflow}, 32'h0);
    chk("rst.data", in_port_data, 32'h0);
    idle();
    chk("rst.nowrite", {28'h0, count}, 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 250) == 0, ($urandom % 3) != 0, $urandom,
           ($urandom % 2) == 1, ($urandom % 16) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
